axi_lite_cfg_master: RTL and testbench
======================================

AXI_LITE_CFG_MASTER -- requirements
Module: axi_lite_cfg_master

Interface
REQ-001 Parameter AXI_DATA_WIDTH, default 32, SHALL set the AXI4-Lite data width and the cmd/rsp data width.
REQ-002 Parameter AXI_ADDR_WIDTH, default 32, SHALL set the AXI4-Lite address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the per-transaction timeout in clk cycles.
REQ-004 Clocking SHALL be one clock; reset SHALL be synchronous and active-high.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-008 cmd_write  in  1  1=write, 0=read.
REQ-009 cmd_addr  in  AXI_ADDR_WIDTH  target register address.
REQ-010 cmd_wdata/cmd_wstrb  in  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8  write data and strobes.
REQ-011 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-012 rsp_rdata  out  AXI_DATA_WIDTH  read data; 0 for writes.
REQ-013 rsp_resp  out  2  captured BRESP/RRESP.
REQ-014 rsp_timeout  out  1  transaction aborted by timeout.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 m_axi_aw{valid,addr,prot} out, m_axi_awready in; m_axi_w{valid,data,strb} out, m_axi_wready in; m_axi_b{valid,resp} in, m_axi_bready out; m_axi_ar{valid,addr,prot} out, m_axi_arready in; m_axi_r{valid,data,resp} in, m_axi_rready out  AXI4-Lite master port, widths per parameters, prot 3.

Function
REQ-017 FSM states SHALL be IDLE, WADDR (AW/W pending), WRESP, RADDR, RDATA, RSP.
REQ-018 cmd_ready SHALL equal (state==IDLE); command accepted on cmd_valid&&cmd_ready and all cmd_* fields registered then.
REQ-019 IDLE->WADDR on accepted write; IDLE->RADDR on accepted read.
REQ-020 In WADDR awvalid and wvalid SHALL both assert the cycle after accept; each SHALL deassert independently the cycle after its own handshake; WADDR->WRESP when both handshakes done (same cycle or different cycles).
REQ-021 WRESP: bready=1; on bvalid capture bresp, rdata=0, go RSP.
REQ-022 RADDR: arvalid=1; on arready go RDATA. RDATA: rready=1; on rvalid capture rdata/rresp, go RSP.
REQ-023 RSP: rsp_valid=1, outputs stable until rsp_ready; on rsp_valid&&rsp_ready go IDLE; next command accepted no earlier than the following cycle.
REQ-024 awprot/arprot SHALL be 3'b000; awaddr/araddr/wdata/wstrb SHALL hold stable while their valid is high.
REQ-025 Latency with zero-wait slave: accept at cycle 0, AW/W/AR valid at cycle 1, rsp_valid at cycle 3.
REQ-026 Timeout counter SHALL clear on accept, increment each cycle in WADDR/WRESP/RADDR/RDATA, saturate; on reaching TIMEOUT_CYCLES all AXI valids/readies SHALL drop next cycle and state go RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
REQ-027 A handshake completing in the same cycle the counter reaches TIMEOUT_CYCLES SHALL take priority (normal completion, no timeout).
REQ-028 B or R beats arriving outside WRESP/RDATA SHALL be ignored (bready/rready low).
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 On rst: state IDLE, cmd_ready=1 after reset release, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, busy=0, all m_axi valid/ready=0, addr/data/strb=0, counter=0.
REQ-031 rst mid-transaction SHALL abort immediately, producing no response and no further AXI activity.

Verification
REQ-032 Write 0x0000_0004 data 0x0000_0001 strb 0xF, slave always ready, bresp=0 -> aw/w valid cycle 1, bready cycle 2, rsp_valid cycle 3, rsp_resp=0, rsp_rdata=0.
REQ-033 Read 0x0000_0008, arready delayed 3 cycles, rdata=0xDEAD_BEEF rresp=0 -> arvalid held 4 cycles with stable araddr, rsp_rdata=0xDEAD_BEEF.
REQ-034 Write with wready 2 cycles after awready -> awvalid drops after its handshake, wvalid held until its own, exactly one B accepted.
REQ-035 TIMEOUT_CYCLES=16, slave never asserts arready -> arvalid drops after 16 cycles, rsp_resp=2'b10, rsp_timeout=1.
REQ-036 rsp_ready held low 5 cycles in RSP -> rsp_* stable, cmd_ready=0 throughout; next command accepted after rsp handshake.
REQ-037 rst asserted in WRESP -> next cycle all outputs at reset values, no rsp_valid.

Source files
------------

// File: rtl/axi_lite_cfg_master.sv
// axi_lite_cfg_master
//
// Turns single register-access commands into AXI4-Lite transactions. It issues one
// transaction at a time and returns a response with the captured BRESP/RRESP and read data.
// A per-transaction timeout turns a stalled slave into a SLVERR-coded response with
// rsp_timeout set.
//
// Ports
//   clk, rst                 sole clock; synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (cmd_ready high only when idle)
//   cmd_write                1 = write, 0 = read
//   cmd_addr                 target register address
//   cmd_wdata, cmd_wstrb     write data and byte strobes
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata                read data (0 for writes and timeouts)
//   rsp_resp                 captured BRESP/RRESP, or 2'b10 on timeout
//   rsp_timeout              transaction aborted by timeout
//   busy                     high whenever a command is in flight or its response is pending
//   m_axi_*                  AXI4-Lite master port (AW, W, B, AR, R channels)
//
// Every output is driven straight from a flop.

module axi_lite_cfg_master #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        rsp_timeout,
    output logic                        busy,

    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                  m_axi_awprot,

    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,

    input  logic                        m_axi_bvalid,
    input  logic [1:0]                  m_axi_bresp,
    output logic                        m_axi_bready,

    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                  m_axi_arprot,

    input  logic                        m_axi_rvalid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    output logic                        m_axi_rready
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        RSP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;
    logic             aw_hs;
    logic             w_hs;
    logic             waddr_done;
    logic             active;
    logic             advance;
    logic             abort;

    // Protection attributes are fixed: unprivileged, secure, data access.
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    always_comb begin
        cnt_inc     = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
        timeout_hit = (cnt_inc == CNT_MAX);

        aw_hs = m_axi_awvalid && m_axi_awready;
        w_hs  = m_axi_wvalid && m_axi_wready;
        // A channel whose valid is already low in WADDR has finished its handshake.
        waddr_done = (!m_axi_awvalid || aw_hs) && (!m_axi_wvalid || w_hs);

        active  = 1'b0;
        advance = 1'b0;
        case (state)
            WADDR: begin
                active  = 1'b1;
                advance = waddr_done;
            end
            WRESP: begin
                active  = 1'b1;
                advance = m_axi_bvalid;
            end
            RADDR: begin
                active  = 1'b1;
                advance = m_axi_arvalid && m_axi_arready;
            end
            RDATA: begin
                active  = 1'b1;
                advance = m_axi_rvalid;
            end
            default: begin
                active  = 1'b0;
                advance = 1'b0;
            end
        endcase

        // The handshake that moves the FSM on wins over a timeout in the same cycle.
        // Once saturated, the counter fires again in any later state that does not advance.
        abort = active && !advance && timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_timeout   <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_rready  <= 1'b0;
        end else if (abort) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b10;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= RSP;
        end else begin
            if (active) begin
                cnt <= cnt_inc;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb[STRB_W-1:0];
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WADDR;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= RADDR;
                        end
                    end
                end

                WADDR: begin
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (w_hs) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if (waddr_done) begin
                        m_axi_bready <= 1'b1;
                        state        <= WRESP;
                    end
                end

                WRESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_timeout  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end

                RADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RDATA;
                    end
                end

                RDATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_timeout  <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// Testbench for axi_lite_cfg_master: directed corner cases plus randomized transactions.
// Expected per-cycle channel activity, response timing and contents come from delay
// arithmetic and a word-array memory model updated from the issued commands.

module tb_axi_lite_cfg_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]    m_axi_awprot, m_axi_arprot;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]    m_axi_wstrb;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;
    logic [1:0]    m_axi_bresp, m_axi_rresp;

    int checks   = 0;
    int failures = 0;

    logic [31:0] slave_mem [8];
    logic [31:0] model_mem [8];

    always #5 clk = ~clk;

    axi_lite_cfg_master #(
        .AXI_DATA_WIDTH (DW),
        .AXI_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bready  (m_axi_bready),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rready  (m_axi_rready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic slave_idle();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check_eq({tag, "_rsp_resp"}, rsp_resp, 0);
        check_eq({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check_eq({tag, "_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        check_eq({tag, "_readies"}, {m_axi_bready, m_axi_rready}, 0);
        check_eq({tag, "_awaddr"}, m_axi_awaddr, 0);
        check_eq({tag, "_araddr"}, m_axi_araddr, 0);
        check_eq({tag, "_wdata"}, m_axi_wdata, 0);
        check_eq({tag, "_wstrb"}, m_axi_wstrb, 0);
    endtask

    // One command end to end. Delays count cycles a channel waits before the slave side
    // acts; NEVER means the slave never responds on that channel.
    task automatic run_txn(input bit wr, input int idx, input logic [31:0] wd,
                           input logic [3:0] ws, input int aw_d, input int w_d, input int b_d,
                           input int ar_d, input int r_d, input int rsp_d,
                           input logic [1:0] resp);
        logic [31:0] addr, exp_rdata, cap_addr, cap_data;
        logic [3:0]  cap_strb;
        logic [1:0]  exp_resp;
        int          m, a, done, lim, fin, tc, b_cnt, rsp_wait;
        bit          exp_to, finished, b_taken, r_taken;

        addr = 32'(idx * 4);
        m = 0; a = 0; done = 0; tc = 1 << 30; exp_to = 1'b0;
        cap_addr = '0; cap_data = '0; cap_strb = '0;
        if (wr) begin
            m = 1 + imax(aw_d, w_d);          // cycle both AW and W have handshaken
            if (m > TO) begin
                exp_to = 1'b1;
                tc     = TO;
            end else begin
                done   = m + 1 + b_d;
                lim    = imax(TO, m + 1);
                exp_to = done > lim;
                if (exp_to) tc = lim;
            end
        end else begin
            a = 1 + ar_d;                     // cycle of the AR handshake
            if (a > TO) begin
                exp_to = 1'b1;
                tc     = TO;
            end else begin
                done   = a + 1 + r_d;
                lim    = imax(TO, a + 1);
                exp_to = done > lim;
                if (exp_to) tc = lim;
            end
        end
        fin       = exp_to ? tc : done;
        exp_resp  = exp_to ? 2'b10 : resp;
        exp_rdata = (wr || exp_to) ? 32'h0 : model_mem[idx];
        if (wr && !exp_to) begin
            for (int i = 0; i < 4; i++) begin
                if (ws[i]) model_mem[idx][8*i +: 8] = wd[8*i +: 8];
            end
        end

        @(negedge clk);
        check_eq("cmd_ready_idle", cmd_ready, 1);
        check_eq("busy_idle", busy, 0);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_wstrb = ws;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);

        finished = 1'b0; b_taken = 1'b0; r_taken = 1'b0; b_cnt = 0; rsp_wait = 0;
        for (int k = 1; k <= 80 && !finished; k++) begin
            check_eq("awvalid", m_axi_awvalid, wr && k <= imin(1 + aw_d, tc));
            check_eq("wvalid", m_axi_wvalid, wr && k <= imin(1 + w_d, tc));
            check_eq("bready", m_axi_bready, wr && k > m && k <= imin(done, tc));
            check_eq("arvalid", m_axi_arvalid, !wr && k <= imin(1 + ar_d, tc));
            check_eq("rready", m_axi_rready, !wr && k > a && k <= imin(done, tc));
            check_eq("rsp_valid", rsp_valid, k > fin);
            check_eq("cmd_ready_busy", cmd_ready, 0);
            check_eq("busy", busy, 1);
            check_eq("prot", {m_axi_awprot, m_axi_arprot}, 0);
            if (m_axi_awvalid) check_eq("awaddr", m_axi_awaddr, addr);
            if (m_axi_wvalid) begin
                check_eq("wdata", m_axi_wdata, wd);
                check_eq("wstrb", m_axi_wstrb, ws);
            end
            if (m_axi_arvalid) check_eq("araddr", m_axi_araddr, addr);

            // Slave side for this cycle.
            m_axi_awready = (k >= 1 + aw_d);
            m_axi_wready  = (k >= 1 + w_d);
            m_axi_arready = (k >= 1 + ar_d);
            if (wr) begin
                m_axi_bvalid = !b_taken && k >= m + 1 + b_d && m <= TO;
                m_axi_bresp  = m_axi_bvalid ? resp : 2'($urandom);
                m_axi_rvalid = 1'b1;        // stray R beat that must be ignored
                m_axi_rdata  = $urandom;
                m_axi_rresp  = 2'($urandom);
            end else begin
                m_axi_rvalid = !r_taken && k >= a + 1 + r_d && a <= TO;
                m_axi_rresp  = m_axi_rvalid ? resp : 2'($urandom);
                m_axi_rdata  = m_axi_rvalid ? slave_mem[cap_addr[4:2]] : $urandom;
                m_axi_bvalid = 1'b1;        // stray B beat that must be ignored
                m_axi_bresp  = 2'($urandom);
            end

            if (m_axi_awvalid && m_axi_awready) cap_addr = m_axi_awaddr;
            if (m_axi_arvalid && m_axi_arready) cap_addr = m_axi_araddr;
            if (m_axi_wvalid && m_axi_wready) begin
                cap_data = m_axi_wdata;
                cap_strb = m_axi_wstrb;
            end
            if (wr && m_axi_bvalid && m_axi_bready) begin
                b_taken = 1'b1;
                b_cnt++;
                for (int i = 0; i < 4; i++) begin
                    if (cap_strb[i]) slave_mem[cap_addr[4:2]][8*i +: 8] = cap_data[8*i +: 8];
                end
            end
            if (!wr && m_axi_rvalid && m_axi_rready) r_taken = 1'b1;

            if (rsp_valid) begin
                check_eq("rsp_rdata", rsp_rdata, exp_rdata);
                check_eq("rsp_resp", rsp_resp, exp_resp);
                check_eq("rsp_timeout", rsp_timeout, exp_to);
                rsp_ready = (rsp_wait >= rsp_d);
                if (rsp_ready) finished = 1'b1;
                rsp_wait++;
            end else begin
                rsp_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end

        check_eq("rsp_handshake_seen", finished, 1);
        rsp_ready = 1'b0;
        slave_idle();
        check_eq("rsp_valid_after_hs", rsp_valid, 0);
        check_eq("cmd_ready_after_hs", cmd_ready, 1);
        check_eq("busy_after_hs", busy, 0);
        check_eq("b_count", b_cnt, (wr && !exp_to) ? 1 : 0);
    endtask

    task automatic reset_mid_txn();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0010;
        cmd_wdata = 32'h1234_5678;
        cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid     = 1'b0;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        @(negedge clk);
        check_eq("rst_pre_bready", m_axi_bready, 1);
        rst          = 1'b1;
        m_axi_bvalid = 1'b1;           // a B beat in the reset cycle must not complete
        m_axi_bresp  = 2'b00;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("post_rst_rsp_valid", rsp_valid, 0);
            check_eq("post_rst_axi", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                                      m_axi_bready, m_axi_rready}, 0);
            check_eq("post_rst_busy", busy, 0);
        end
        slave_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  wr, dl [5];
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        slave_idle();
        for (int i = 0; i < 8; i++) begin
            slave_mem[i] = '0;
            model_mem[i] = '0;
        end
        slave_mem[2] = 32'hDEAD_BEEF;
        model_mem[2] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Zero-wait write, then read with delayed AR, then independent AW/W handshakes.
        run_txn(1, 1, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00);
        run_txn(0, 2, 32'h0, 4'h0, 0, 0, 0, 3, 0, 0, 2'b00);
        run_txn(1, 3, 32'hA5A5_0F0F, 4'hF, 0, 2, 1, 0, 0, 1, 2'b00);
        // Slave never accepts AR.
        run_txn(0, 5, 32'h0, 4'h0, 0, 0, 0, NEVER, 0, 0, 2'b00);
        // Held-off response, reading back the first write.
        run_txn(0, 1, 32'h0, 4'h0, 0, 0, 0, 0, 0, 5, 2'b00);
        // Timeouts in WADDR and WRESP.
        run_txn(1, 4, 32'hCAFE_F00D, 4'hF, NEVER, 0, 0, 0, 0, 0, 2'b00);
        run_txn(1, 4, 32'hCAFE_F00D, 4'hF, 0, NEVER, 0, 0, 0, 0, 2'b00);
        run_txn(1, 6, 32'h1111_2222, 4'hF, 0, 0, NEVER, 0, 0, 0, 2'b00);
        // Completion exactly on the timeout cycle, and one cycle too late.
        run_txn(0, 2, 32'h0, 4'h0, 0, 0, 0, 14, 0, 0, 2'b01);
        run_txn(0, 2, 32'h0, 4'h0, 0, 0, 0, 14, 1, 0, 2'b00);
        run_txn(1, 7, 32'h5555_AAAA, 4'h5, 3, 7, 5, 0, 0, 0, 2'b11);
        run_txn(0, 7, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00);

        reset_mid_txn();
        run_txn(0, 1, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00);

        for (int n = 0; n < 150; n++) begin
            wr = int'($urandom_range(0, 1));
            for (int i = 0; i < 5; i++) begin
                dl[i] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(10, 20))
                                                     : int'($urandom_range(0, 4));
            end
            run_txn(wr[0], int'($urandom_range(0, 7)), $urandom, 4'($urandom),
                    dl[0], dl[1], dl[2], dl[3], dl[4],
                    ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 2)),
                    2'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
